// File: rtl/ram_fifo_ctrl_if.sv
// Stream handshake bundle for ram_fifo_ctrl: byte write stream in, byte read stream out.
// master = upstream/downstream logic, slave = the FIFO controller.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a single-port RAM with 1-cycle registered read, prefetching into a 1-entry output register.
// Optional synchronous flush input clr when FIFO_CLEAR_EN is defined.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
`ifdef FIFO_CLEAR_EN
    input  logic              clr,
`endif
    ram_fifo_ctrl_if.slave    bus,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   ram_cnt_reg, ram_cnt_next;
    logic              rd_pend_reg, rd_pend_next;
    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;

    logic clr_act;
    logic pop;
    logic rd_issue;
    logic wr_ready;
    logic push;

`ifdef FIFO_CLEAR_EN
    assign clr_act = clr;
`else
    assign clr_act = 1'b0;
`endif

    // Reads win the single RAM port; the write side only gets cycles the prefetch does not need.
    assign pop      = out_valid_reg & bus.rd_ready;
    assign rd_issue = (ram_cnt_reg != '0) & ~rd_pend_reg & (~out_valid_reg | pop) & ~clr_act;
    assign wr_ready = rstn & (ram_cnt_reg != DEPTH_CNT) & ~rd_issue & ~clr_act;
    assign push     = bus.wr_valid & wr_ready;

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = out_valid_reg;
    assign bus.rd_data  = out_data_reg;

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = rd_ptr_reg;
        ram_wdata = bus.wr_data;
        if (rd_issue) begin
            ram_re   = 1'b1;
            ram_addr = rd_ptr_reg;
        end else if (push) begin
            ram_we   = 1'b1;
            ram_addr = wr_ptr_reg;
        end
    end

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        ram_cnt_next   = ram_cnt_reg;
        rd_pend_next   = rd_pend_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        if (clr_act) begin
            // Flush discards everything, including an in-flight read and the presented byte.
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            ram_cnt_next   = '0;
            rd_pend_next   = 1'b0;
            out_valid_next = 1'b0;
        end else begin
            if (rd_issue) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (push) begin
                ram_cnt_next = ram_cnt_reg + 1'b1;
            end else if (rd_issue) begin
                ram_cnt_next = ram_cnt_reg - 1'b1;
            end
            // rd_issue is never set while rd_pend_reg is, so this also clears the pending flag.
            rd_pend_next = rd_issue;
            if (rd_pend_reg) begin
                out_valid_next = 1'b1;
                out_data_next  = ram_rdata;
            end else if (pop) begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_cnt_reg   <= '0;
            rd_pend_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ram_cnt_reg   <= ram_cnt_next;
            rd_pend_reg   <= rd_pend_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    // Occupancy counts bytes in RAM, the byte in flight and the presented byte.
    assign count = ram_cnt_reg
                 + {{ADDR_W{1'b0}}, rd_pend_reg}
                 + {{ADDR_W{1'b0}}, out_valid_reg};
    assign full  = (ram_cnt_reg == DEPTH_CNT);
    assign empty = (count == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_ram_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clr = 1'b0;
    logic       ram_we, ram_re;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic [4:0] count;
    logic       full, empty;

    ram_fifo_ctrl_if #(.DATA_W(8)) bus ();

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
`ifdef FIFO_CLEAR_EN
        .clr      (clr),
`endif
        .bus      (bus),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    // 16x8 single-port RAM with registered read
    logic [7:0] mem [0:15];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state: bytes resident in RAM, byte in flight, presented byte.
    byte unsigned m_ram[$];
    bit           m_pend = 0;
    byte unsigned m_pend_d = 0;
    bit           m_ov = 0;
    byte unsigned m_od = 0;
    int           m_wp = 0, m_rp = 0;
    byte unsigned sb[$];
    byte unsigned popped[$];

    bit d_rst = 1, d_clr = 0, d_push = 0, d_issue = 0, d_pop = 0;
    byte unsigned d_wd = 0;
    bit e_clr, e_pop, e_issue, e_wrdy, e_push;
    int e_cnt;
    bit track = 0;
    int first_push_edge = -1, first_valid_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_rd_valid", bus.rd_valid, 0);
            chk("rst_rd_data", bus.rd_data, 0);
            chk("rst_wr_ready", bus.wr_ready, 0);
            chk("rst_we_re", {ram_we, ram_re}, 0);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            d_rst = 1; d_clr = 0; d_push = 0; d_issue = 0; d_pop = 0;
        end else begin
`ifdef FIFO_CLEAR_EN
            e_clr = clr;
`else
            e_clr = 0;
`endif
            e_pop   = m_ov && bus.rd_ready;
            e_issue = (m_ram.size() != 0) && !m_pend && (!m_ov || e_pop) && !e_clr;
            e_wrdy  = (m_ram.size() != 16) && !e_issue && !e_clr;
            e_push  = bus.wr_valid && e_wrdy;
            e_cnt   = m_ram.size() + int'(m_pend) + int'(m_ov);
            chk("rd_valid", bus.rd_valid, m_ov);
            chk("rd_data", bus.rd_data, m_od);
            chk("wr_ready", bus.wr_ready, e_wrdy);
            chk("count", count, e_cnt);
            chk("full", full, m_ram.size() == 16);
            chk("empty", empty, e_cnt == 0);
            chk("ram_we", ram_we, e_push);
            chk("ram_re", ram_re, e_issue);
            chk("we_re_excl", ram_we & ram_re, 0);
            chk("ram_addr", ram_addr, e_push && !e_issue ? m_wp : m_rp);
            if (e_push) chk("ram_wdata", ram_wdata, bus.wr_data);
            if (e_pop && !e_clr) begin
                if (sb.size() != 0) chk("order", bus.rd_data, sb.pop_front());
                else chk("order_underflow", 1, 0);
                popped.push_back(bus.rd_data);
            end
            if (e_push) sb.push_back(bus.wr_data);
            if (track && e_push && first_push_edge < 0) first_push_edge = cyc + 1;
            if (track && bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            d_rst = 0; d_clr = e_clr; d_push = e_push; d_issue = e_issue;
            d_pop = e_pop; d_wd = bus.wr_data;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (d_rst || d_clr) begin
            m_ram.delete(); sb.delete();
            m_pend = 0; m_ov = 0; m_wp = 0; m_rp = 0;
            if (d_rst) m_od = 0;
        end else begin
            if (m_pend) begin
                m_od = m_pend_d; m_ov = 1;
            end else if (d_pop) begin
                m_ov = 0;
            end
            m_pend = d_issue;
            if (d_issue) begin
                m_pend_d = m_ram.pop_front();
                m_rp = (m_rp + 1) % 16;
            end
            if (d_push) begin
                m_ram.push_back(d_wd);
                m_wp = (m_wp + 1) % 16;
            end
        end
    end

    task automatic drive(input bit wv, input byte unsigned wd, input bit rr);
        bus.wr_valid = wv; bus.wr_data = wd; bus.rd_ready = rr;
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input byte unsigned wd, input bit rr);
        int n = 0;
        bit done = 0;
        bus.wr_valid = 1; bus.wr_data = wd; bus.rd_ready = rr;
        while (!done && n < 40) begin
            @(negedge clk);
            done = bus.wr_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.wr_valid = 0;
        chk("push_accept", done, 1);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) drive(0, 8'h00, rr);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.wr_valid = 0; bus.wr_data = 0; bus.rd_ready = 0;
        idle(3, 0);
        chk("lit_reset_count", count, 0);
        rstn = 1;
        idle(2, 0);

        // Short in-order stream and first-data latency
        popped.delete(); track = 1;
        push_byte(8'h11, 1); push_byte(8'h22, 1); push_byte(8'h33, 1);
        idle(10, 1);
        track = 0;
        chk("t1_npop", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("t1_b0", popped[0], 8'h11);
            chk("t1_b1", popped[1], 8'h22);
            chk("t1_b2", popped[2], 8'h33);
        end
        chk("t1_latency", first_valid_cyc - first_push_edge, 2);
        chk("t1_count", count, 0);
        chk("t1_empty", empty, 1);

        // Fill to full with the reader stalled
        popped.delete();
        for (int v = 0; v < 17; v++) push_byte(8'(v), 0);
        chk("t2_count", count, 17);
        chk("t2_full", full, 1);
        for (int i = 0; i < 5; i++) drive(1, 8'h55, 0);
        chk("t2_hold_count", count, 17);
        chk("t2_hold_wr_ready", bus.wr_ready, 0);
        bus.wr_valid = 0;
        idle(50, 1);
        chk("t2_npop", popped.size(), 17);
        for (int i = 0; i < 17; i++)
            if (i < popped.size()) chk("t2_data", popped[i], i);

        // Continuous traffic across pointer wraps
        popped.delete();
        for (int i = 0; i < 40; i++) push_byte(8'($urandom_range(0, 255)), 1);
        idle(10, 1);
        chk("t3_npop", popped.size(), 40);

        // Stalled output holds its byte
        push_byte(8'h77, 0);
        idle(3, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_rd_valid", bus.rd_valid, 1);
            chk("t4_rd_data", bus.rd_data, 8'h77);
            drive(0, 8'h00, 0);
        end
        idle(10, 1);

        // Reset with a read in flight
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i), 0);
        idle(2, 0);
        drive(0, 8'h00, 1);
        rstn = 0;
        #2;
        chk("t5_rd_valid", bus.rd_valid, 0);
        chk("t5_count", count, 0);
        chk("t5_wr_ready", bus.wr_ready, 0);
        drive(0, 8'h00, 0);
        rstn = 1;
        popped.delete();
        push_byte(8'hA5, 1);
        idle(5, 1);
        chk("t5_npop", popped.size(), 1);
        if (popped.size() == 1) chk("t5_data", popped[0], 8'hA5);

`ifdef FIFO_CLEAR_EN
        for (int i = 0; i < 6; i++) push_byte(8'(i + 1), 0);
        idle(2, 0);
        clr = 1;
        drive(1, 8'h5A, 0);
        clr = 0;
        bus.wr_valid = 0;
        chk("t6_count", count, 0);
        popped.delete();
        push_byte(8'h3C, 1);
        idle(5, 1);
        chk("t6_npop", popped.size(), 1);
        if (popped.size() == 1) chk("t6_data", popped[0], 8'h3C);
`endif

        // Random traffic with occasional reset / flush
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rstn = 0;
                drive(0, 8'h00, 0);
                rstn = 1;
            end
`ifdef FIFO_CLEAR_EN
            clr = ($urandom_range(0, 99) == 0);
`endif
            drive($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        end
        clr = 0;
        idle(50, 1);
        chk("final_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller for the team's 16x8 single-port RAM (one shared address, registered read data, 1-cycle read latency).
- Converts a valid/ready byte stream on the write side into RAM writes.
- Prefetches RAM contents into a 1-entry output register presented on a valid/ready read side.
- Issues at most one RAM operation per cycle and owns all RAM control pins.

Parameters:
- DATA_W, 8, data width; matches RAM word.
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W = 16 entries.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- wr_valid  in  1  upstream byte valid.
- wr_data  in  DATA_W  upstream byte.
- wr_ready  out  1  controller accepts wr_data this cycle.
- rd_valid  out  1  rd_data holds a valid byte.
- rd_data  out  DATA_W  head-of-FIFO byte.
- rd_ready  in  1  downstream takes rd_data this cycle.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM registered read data.
- count  out  ADDR_W+1  total bytes held: RAM + in-flight read + output register.
- full  out  1  RAM holds DEPTH entries.
- empty  out  1  count == 0.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr (ADDR_W bits, wrap DEPTH-1 -> 0).
  - ram_cnt (ADDR_W+1 bits, 0..DEPTH).
  - rd_pend (a RAM read was issued last cycle).
  - out_valid, out_data.
- Reset (rstn low, async): all state = 0, rd_valid = 0, rd_data = 0, ram_we = ram_re = 0, wr_ready = 0, count = 0, empty = 1, full = 0.
- pop = rd_valid & rd_ready.
- rd_issue = (ram_cnt != 0) & !rd_pend & (!out_valid | pop).
- Reads take priority over writes.
- wr_ready = rstn & (ram_cnt != DEPTH) & !rd_issue. This is combinational from rd_ready; permitted.
- push = wr_valid & wr_ready.
- RAM drive (combinational):
  - rd_issue: ram_re = 1, ram_addr = rd_ptr.
  - else push: ram_we = 1, ram_addr = wr_ptr, ram_wdata = wr_data.
  - else: both enables 0, ram_addr = rd_ptr.
- On rd_issue: rd_ptr++, ram_cnt--, rd_pend <= 1.
- On push: wr_ptr++, ram_cnt++.
- push and rd_issue are mutually exclusive by construction.
- When rd_pend = 1: out_data <= ram_rdata, out_valid <= 1, rd_pend <= 0.
- On pop without capture: out_valid <= 0.
- A capture and a pop never coincide: rd_issue implies out_valid is empty or being popped.
- rd_data = out_data; it holds stable while rd_valid & !rd_ready.
- Latency: a byte pushed into an empty FIFO at edge N is issued at N+1, captured at N+2, and rd_valid is high from N+2.
- Throughput: 1 byte per cycle on the write side. The read side sustains 1 byte per 2 cycles while draining.
- full: the next push is refused (wr_ready = 0). Holding wr_valid high must not corrupt state.
- empty: rd_valid = 0. rd_ready is ignored.
- Wrap: pointers roll 15 -> 0 without gaps; ordering is strictly FIFO across the wrap.
- Reset mid-operation: pending read and output byte are discarded immediately. The RAM is not cleared by this block.

Optional Feature:
- Macro FIFO_CLEAR_EN.
- Defined: adds input port clr (1 bit, synchronous, active-high).
  - On a clr edge: pointers, ram_cnt, rd_pend and out_valid go to 0.
  - ram_we and ram_re are forced 0 in that cycle; wr_ready = 0.
  - clr overrides simultaneous push or pop.
- Not defined: no clr port; state is flushed only by rstn.

Test Plan:
- Reset then push 0x11, 0x22, 0x33 with rd_ready = 1 -> rd_data 0x11, 0x22, 0x33 in order. First rd_valid is exactly 2 cycles after the 0x11 handshake. count returns to 0 and empty = 1.
- rd_ready = 0, push 17 bytes 0x00..0x10 -> first 16 accepted plus 0..1 prefetched. Continued wr_valid does not change state. Then drain: exactly the accepted bytes emerge in order, no 0x10 duplication.
- Push and pop continuously for 40 bytes -> pointers wrap at least twice. Output equals input sequence. ram_we and ram_re are never high together.
- rd_valid high with rd_ready held 0 for 5 cycles -> rd_data stays constant. count stays constant except for pushes.
- Assert rstn low during an in-flight read with 4 bytes stored -> next cycle rd_valid = 0, count = 0, wr_ready = 0. After release, a push of 0xA5 reads back 0xA5.
- FIFO_CLEAR_EN: 6 bytes stored, clr pulsed together with wr_valid (0x5A) -> count = 0 next cycle, 0x5A is dropped, and the next push of 0x3C is the first byte out.
